// File: rtl/ccm_ctr_pkg.sv
// rtl/ccm_ctr_pkg.sv - shared types and helpers for the CCM CTR stream engine
package ccm_ctr_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    function automatic int beats_per_blk(input int data_w);
        return AES_BLK_W / data_w;
    endfunction

    // LSB-aligned keep mask for a data_w-bit beat whose first n_bytes bytes (MSB end) are valid.
    function automatic logic [AES_BLK_W-1:0] byte_mask(input int data_w, input int n_bytes);
        logic [AES_BLK_W-1:0] full;
        full = {AES_BLK_W{1'b1}} >> (AES_BLK_W - data_w);
        return full & ~(full >> (8 * n_bytes));
    endfunction

endpackage

// File: rtl/ccm_ctr_ks_fifo.sv
// rtl/ccm_ctr_ks_fifo.sv - keystream block FIFO with flush
module ccm_ctr_ks_fifo
    import ccm_ctr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         kill_n,
    input  logic                         push,
    input  logic [AES_BLK_W-1:0]         push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [AES_BLK_W-1:0]         head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [AES_BLK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Flush overrides a same-cycle push or pop: the whole stream is being abandoned.
    always_ff @(posedge clk) begin
        if (!kill_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/ccm_ctr_stream_engine.sv
// rtl/ccm_ctr_stream_engine.sv - CCM CTR-mode keystream generator and XOR datapath
module ccm_ctr_stream_engine
    import ccm_ctr_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WIDTH_NONCE = 104,
    parameter int WIDTH_FLAG  = 8,
    parameter int WIDTH_COUNT = 16,
    parameter int KS_DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       kill_n,
    input  logic                       start,
    input  logic [WIDTH_NONCE-1:0]     ccm_ctr_nonce,
    input  logic [WIDTH_FLAG-1:0]      ccm_ctr_flag,
    input  logic [WIDTH_COUNT-1:0]     ctr_init,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [$clog2(DATA_W/8):0]  in_bytes,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DATA_W/8):0]  out_bytes,
    output logic [AES_BLK_W-1:0]       aes_req_data,
    output logic                       aes_req_valid,
    input  logic                       aes_req_ready,
    input  logic [AES_BLK_W-1:0]       aes_rsp_data,
    input  logic                       aes_rsp_valid,
    output logic                       busy,
    output logic                       ctr_overflow_err
);

    localparam int BPB    = beats_per_blk(DATA_W);
    localparam int BEAT_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int CNT_W  = $clog2(KS_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPB - 1);

    state_t                    state_q, state_d;
    logic [WIDTH_FLAG-1:0]     flag_q;
    logic [WIDTH_NONCE-1:0]    nonce_q;
    logic [WIDTH_COUNT-1:0]    ctr_q;
    logic                      wrap_q, err_q;
    logic [CNT_W-1:0]          osd_q;
    logic [BEAT_W-1:0]         beat_q;
    logic                      out_valid_q, out_last_q;
    logic [DATA_W-1:0]         out_data_q;
    logic [$clog2(DATA_W/8):0] out_bytes_q;

    logic                      fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [AES_BLK_W-1:0]      fifo_head, ks_shift;
    logic [CNT_W-1:0]          fifo_count;
    logic [DATA_W-1:0]         ks_slice, beat_mask, out_next;
    logic                      start_ok, req_fire, rsp_take, in_fire, blk_done, starve_err;

    assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_ERR);
    assign aes_req_valid = (state_q == ST_RUN) && !wrap_q &&
                           (({1'b0, fifo_count} + {1'b0, osd_q}) < SUM_W'(KS_DEPTH));
    assign aes_req_data  = {flag_q, nonce_q, ctr_q};
    assign req_fire   = aes_req_valid && aes_req_ready;
    // With nothing outstanding a response is stale (e.g. issued before a kill) and is ignored.
    assign rsp_take   = aes_rsp_valid && (osd_q != '0);
    assign in_ready   = (state_q == ST_RUN) && !fifo_empty && (!out_valid_q || out_ready);
    assign in_fire    = in_valid && in_ready;
    assign blk_done   = in_fire && (in_last || beat_q == LAST_BEAT);
    assign starve_err = (state_q == ST_RUN) && wrap_q && fifo_empty && (osd_q == '0) && in_valid;

    assign fifo_push  = rsp_take && (state_q == ST_RUN);
    assign fifo_pop   = blk_done;
    assign fifo_flush = (in_fire && in_last) || starve_err;

    ccm_ctr_ks_fifo #(
        .DEPTH(KS_DEPTH)
    ) u_ks_fifo (
        .clk       (clk),
        .kill_n    (kill_n),
        .push      (fifo_push),
        .push_data (aes_rsp_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign ks_shift  = fifo_head << (beat_q * DATA_W);
    assign ks_slice  = ks_shift[AES_BLK_W-1 -: DATA_W];
    assign beat_mask = in_last ? DATA_W'(byte_mask(DATA_W, int'(in_bytes))) : '1;
    assign out_next  = (in_data ^ ks_slice) & beat_mask;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (starve_err)              state_d = ST_ERR;
                else if (in_fire && in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (osd_q == '0 && (!out_valid_q || out_ready)) state_d = ST_IDLE;
            ST_ERR:   if (start_ok) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            state_q     <= ST_IDLE;
            flag_q      <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            osd_q       <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                flag_q  <= ccm_ctr_flag;
                nonce_q <= ccm_ctr_nonce;
                ctr_q   <= ctr_init;
                wrap_q  <= 1'b0;
                err_q   <= 1'b0;
                beat_q  <= '0;
            end else if (req_fire) begin
                ctr_q <= ctr_q + 1'b1;
                if (&ctr_q) wrap_q <= 1'b1;
            end
            if (starve_err) err_q <= 1'b1;
            osd_q <= osd_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (blk_done)     beat_q <= '0;
            else if (in_fire) beat_q <= beat_q + 1'b1;
            if (in_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_next;
                out_last_q  <= in_last;
                out_bytes_q <= in_bytes;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_last         = out_last_q;
    assign out_bytes        = out_bytes_q;
    assign busy             = (state_q != ST_IDLE);
    assign ctr_overflow_err = err_q;

endmodule
